// File: rtl/module_types.sv
// Shared types for the OoO core: physical register width, ROB defaults and the ROB entry record.
package module_types;

    localparam int PHYS_REG_ADDR     = 6;
    localparam int ROB_DEPTH_DEFAULT = 16;

    typedef struct packed {
        logic                     valid;
        logic                     done;
        logic                     has_rd;
        logic [4:0]               arch_rd;
        logic [PHYS_REG_ADDR-1:0] phys_rd;
    } rob_entry_t;

    // Only real destinations (not x0) update the RRF and release a physical register
    function automatic logic writes_rrf(input rob_entry_t e);
        return e.has_rd && (e.arch_rd != 5'd0);
    endfunction

endpackage

// File: rtl/rob_commit.sv
// In-order reorder buffer and commit stage; retires the head into the RRF and frees the old mapping.
// Optional retired-instruction counter enabled by defining ROB_COMMIT_COUNTER_EN.
module rob_commit
    import module_types::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
    parameter int ROB_IDX   = $clog2(ROB_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic                     disp_has_rd,
    input  logic [4:0]               disp_arch_rd,
    input  logic [PHYS_REG_ADDR-1:0] disp_phys_rd,
    output logic [ROB_IDX-1:0]       disp_rob_idx,
    input  logic                     cdb_valid,
    input  logic [ROB_IDX-1:0]       cdb_rob_idx,
    input  logic                     flush,
    output logic [4:0]               rrf_r_addr,
    input  logic [PHYS_REG_ADDR-1:0] rrf_r_data,
    output logic                     rrf_w_en,
    output logic [4:0]               rrf_w_addr,
    output logic [PHYS_REG_ADDR-1:0] rrf_w_data,
    output logic                     free_valid,
    output logic [PHYS_REG_ADDR-1:0] free_preg,
    output logic [31:0]              commit_count
);

    localparam logic [ROB_IDX:0]   FULL_COUNT = (ROB_IDX+1)'(ROB_DEPTH);
    localparam logic [ROB_IDX-1:0] IDX_ONE    = ROB_IDX'(1);
    localparam logic [ROB_IDX:0]   CNT_ONE    = (ROB_IDX+1)'(1);

    rob_entry_t          entries [ROB_DEPTH];
    logic [ROB_IDX-1:0]  head;
    logic [ROB_IDX-1:0]  tail;
    logic [ROB_IDX:0]    count;

    rob_entry_t          head_entry;
    logic                commit_fire;
    logic                disp_fire;

    assign head_entry   = entries[head];
    assign disp_rob_idx = tail;
    assign rrf_r_addr   = head_entry.arch_rd;

    // Full-cycle rule: readiness looks only at the registered count, not at a same-cycle retire
    always_comb begin
        disp_ready  = (count != FULL_COUNT);
        disp_fire   = 1'b0;
        commit_fire = 1'b0;
        if (!rst && !flush) begin
            disp_fire   = disp_valid && disp_ready;
            commit_fire = (count != {(ROB_IDX+1){1'b0}}) && head_entry.valid && head_entry.done;
        end else begin
            disp_fire   = 1'b0;
            commit_fire = 1'b0;
        end
    end

    // Commit outputs; free_preg is the RRF's pre-update mapping since the RRF writes at the edge
    always_comb begin
        rrf_w_en   = 1'b0;
        rrf_w_addr = 5'd0;
        rrf_w_data = {PHYS_REG_ADDR{1'b0}};
        free_valid = 1'b0;
        free_preg  = {PHYS_REG_ADDR{1'b0}};
        if (commit_fire && writes_rrf(head_entry)) begin
            rrf_w_en   = 1'b1;
            rrf_w_addr = head_entry.arch_rd;
            rrf_w_data = head_entry.phys_rd;
            free_valid = 1'b1;
            free_preg  = rrf_r_data;
        end else begin
            rrf_w_en   = 1'b0;
            free_valid = 1'b0;
        end
    end

    // Entry storage, pointers and occupancy; rst beats flush, flush beats everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (cdb_valid && entries[cdb_rob_idx].valid) begin
                entries[cdb_rob_idx].done <= 1'b1;
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
                entries[head].done  <= 1'b0;
                head                <= head + IDX_ONE;
            end
            if (disp_fire) begin
                entries[tail].valid   <= 1'b1;
                entries[tail].done    <= 1'b0;
                entries[tail].has_rd  <= disp_has_rd;
                entries[tail].arch_rd <= disp_arch_rd;
                entries[tail].phys_rd <= disp_phys_rd;
                tail                  <= tail + IDX_ONE;
            end
            case ({disp_fire, commit_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef ROB_COMMIT_COUNTER_EN
    logic [31:0] commit_cnt;

    // Retired-instruction counter: survives flush, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt <= 32'd0;
        end else if (commit_fire) begin
            commit_cnt <= commit_cnt + 32'd1;
        end else begin
            commit_cnt <= commit_cnt;
        end
    end

    assign commit_count = commit_cnt;
`else
    assign commit_count = 32'd0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit with a behavioural RRF model.
module tb_rob_commit;
    import module_types::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     disp_valid;
    logic                     disp_ready;
    logic                     disp_has_rd;
    logic [4:0]               disp_arch_rd;
    logic [PHYS_REG_ADDR-1:0] disp_phys_rd;
    logic [3:0]               disp_rob_idx;
    logic                     cdb_valid;
    logic [3:0]               cdb_rob_idx;
    logic                     flush;
    logic [4:0]               rrf_r_addr;
    logic [PHYS_REG_ADDR-1:0] rrf_r_data;
    logic                     rrf_w_en;
    logic [4:0]               rrf_w_addr;
    logic [PHYS_REG_ADDR-1:0] rrf_w_data;
    logic                     free_valid;
    logic [PHYS_REG_ADDR-1:0] free_preg;
    logic [31:0]              commit_count;

    logic [PHYS_REG_ADDR-1:0] rrf [32];
    logic                     rrf_init;

    int passed = 0;
    int total  = 0;
    int cc_exp;

    rob_commit #(.ROB_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_has_rd(disp_has_rd),
        .disp_arch_rd(disp_arch_rd), .disp_phys_rd(disp_phys_rd), .disp_rob_idx(disp_rob_idx),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .flush(flush),
        .rrf_r_addr(rrf_r_addr), .rrf_r_data(rrf_r_data),
        .rrf_w_en(rrf_w_en), .rrf_w_addr(rrf_w_addr), .rrf_w_data(rrf_w_data),
        .free_valid(free_valid), .free_preg(free_preg), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    // RRF model: identity mapping at start, written at the clock edge
    always @(posedge clk) begin
        if (rrf_init) begin
            for (int i = 0; i < 32; i++) rrf[i] <= PHYS_REG_ADDR'(i);
        end else if (rrf_w_en) begin
            rrf[rrf_w_addr] <= rrf_w_data;
        end
    end
    assign rrf_r_data = rrf[rrf_r_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic has_rd, input logic [4:0] arch, input logic [PHYS_REG_ADDR-1:0] phys);
        disp_valid   = 1'b1;
        disp_has_rd  = has_rd;
        disp_arch_rd = arch;
        disp_phys_rd = phys;
    endtask

    task automatic cdb(input logic v, input logic [3:0] idx);
        cdb_valid   = v;
        cdb_rob_idx = idx;
    endtask

    task automatic chk_commit(input string tag, input logic [4:0] a, input logic [PHYS_REG_ADDR-1:0] d,
                              input logic [PHYS_REG_ADDR-1:0] f);
        chk({tag, "_wen"}, 32'(rrf_w_en), 32'd1);
        chk({tag, "_waddr"}, 32'(rrf_w_addr), 32'(a));
        chk({tag, "_wdata"}, 32'(rrf_w_data), 32'(d));
        chk({tag, "_fvalid"}, 32'(free_valid), 32'd1);
        chk({tag, "_fpreg"}, 32'(free_preg), 32'(f));
    endtask

    task automatic chk_cc(input string tag, input int n);
`ifdef ROB_COMMIT_COUNTER_EN
        cc_exp = n;
`else
        cc_exp = 0;
`endif
        chk(tag, commit_count, 32'(cc_exp));
    endtask

    initial begin
        rst = 1'b1; rrf_init = 1'b1; flush = 1'b0;
        disp_valid = 1'b0; disp_has_rd = 1'b0; disp_arch_rd = 5'd0; disp_phys_rd = '0;
        cdb_valid = 1'b0; cdb_rob_idx = 4'd0;
        tick(); tick();
        rst = 1'b0; rrf_init = 1'b0;
        #1;
        chk("rst_ready", 32'(disp_ready), 32'd1);
        chk("rst_idx", 32'(disp_rob_idx), 32'd0);
        chk("rst_wen", 32'(rrf_w_en), 32'd0);
        chk("rst_free", 32'(free_valid), 32'd0);
        chk("rst_cc", commit_count, 32'd0);

        // In-order: arch 1/2/3 -> phys 40/41/42
        disp(1'b1, 5'd1, 6'd40); #1; chk("d0_idx", 32'(disp_rob_idx), 32'd0); tick();
        disp(1'b1, 5'd2, 6'd41); #1; chk("d1_idx", 32'(disp_rob_idx), 32'd1); tick();
        disp(1'b1, 5'd3, 6'd42); #1; chk("d2_idx", 32'(disp_rob_idx), 32'd2); tick();
        disp_valid = 1'b0;
        cdb(1'b1, 4'd0); #1; chk("io_nodone", 32'(rrf_w_en), 32'd0); tick();
        cdb(1'b1, 4'd1); #1; chk_commit("io_c0", 5'd1, 6'd40, 6'd1); tick();
        cdb(1'b1, 4'd2); #1; chk_commit("io_c1", 5'd2, 6'd41, 6'd2); tick();
        cdb(1'b0, 4'd0); #1; chk_commit("io_c2", 5'd3, 6'd42, 6'd3); tick();
        #1; chk("io_idle", 32'(rrf_w_en), 32'd0);
        chk_cc("io_cc", 3);

        // Out-of-order completion: idx 3/4/5 done in order 5,4,3
        disp(1'b1, 5'd4, 6'd43); #1; chk("o0_idx", 32'(disp_rob_idx), 32'd3); tick();
        disp(1'b1, 5'd5, 6'd44); tick();
        disp(1'b1, 5'd6, 6'd45); tick();
        disp_valid = 1'b0;
        cdb(1'b1, 4'd5); #1; chk("oo_w5", 32'(rrf_w_en), 32'd0); tick();
        cdb(1'b1, 4'd4); #1; chk("oo_w4", 32'(rrf_w_en), 32'd0); tick();
        cdb(1'b1, 4'd3); #1; chk("oo_w3", 32'(rrf_w_en), 32'd0); tick();
        cdb(1'b0, 4'd0); #1; chk_commit("oo_c0", 5'd4, 6'd43, 6'd4); tick();
        #1; chk_commit("oo_c1", 5'd5, 6'd44, 6'd5); tick();
        #1; chk_commit("oo_c2", 5'd6, 6'd45, 6'd6); tick();
        #1; chk("oo_idle", 32'(rrf_w_en), 32'd0);

        // Fill all 16 entries starting at tail 6, wrapping 15 -> 0
        for (int i = 0; i < 16; i++) begin
            disp(1'b1, 5'd7, 6'(16 + i)); #1;
            chk("fill_ready", 32'(disp_ready), 32'd1);
            chk("fill_idx", 32'(disp_rob_idx), 32'((6 + i) % 16));
            tick();
        end
        disp(1'b1, 5'd8, 6'd63); #1; chk("full_ready", 32'(disp_ready), 32'd0); tick();
        disp_valid = 1'b0; #1; chk("full_refused", 32'(disp_rob_idx), 32'd6);

        // Complete in order while re-dispatching arch-0 entries once a slot frees
        for (int k = 0; k < 16; k++) begin
            cdb(1'b1, 4'((6 + k) % 16));
            if (k >= 2) disp(1'b1, 5'd0, 6'd0);
            else disp_valid = 1'b0;
            #1;
            if (k == 0) begin
                chk("fl_k0_wen", 32'(rrf_w_en), 32'd0);
                chk("fl_k0_ready", 32'(disp_ready), 32'd0);
            end else begin
                chk_commit("fl_c", 5'd7, 6'(16 + k - 1), (k == 1) ? 6'd7 : 6'(16 + k - 2));
                chk("fl_ready", 32'(disp_ready), (k == 1) ? 32'd0 : 32'd1);
                if (k >= 2) chk("fl_idx", 32'(disp_rob_idx), 32'((4 + k) % 16));
            end
            tick();
        end
        cdb(1'b0, 4'd0); disp_valid = 1'b0;
        #1; chk_commit("fl_last", 5'd7, 6'd31, 6'd30); tick();
        #1; chk("fl_after", 32'(rrf_w_en), 32'd0);
        chk_cc("fl_cc", 22);

        // arch 0 entry at head retires silently
        cdb(1'b1, 4'd6); tick();
        cdb(1'b0, 4'd0); #1;
        chk("a0_wen", 32'(rrf_w_en), 32'd0);
        chk("a0_free", 32'(free_valid), 32'd0);
        tick();
        chk_cc("a0_cc", 23);
        flush = 1'b1; tick(); flush = 1'b0;

        // has_rd=0 and arch 0 retire without RRF write; head then reaches idx2
        disp(1'b0, 5'd10, 6'd55); #1; chk("nr_idx", 32'(disp_rob_idx), 32'd0); tick();
        disp(1'b1, 5'd0, 6'd56); tick();
        disp(1'b1, 5'd11, 6'd57); tick();
        disp_valid = 1'b0;
        cdb(1'b1, 4'd0); tick();
        cdb(1'b1, 4'd1); #1;
        chk("nr_raddr", 32'(rrf_r_addr), 32'd10);
        chk("nr_wen", 32'(rrf_w_en), 32'd0);
        chk("nr_free", 32'(free_valid), 32'd0);
        tick();
        cdb(1'b1, 4'd2); #1;
        chk("z_wen", 32'(rrf_w_en), 32'd0);
        chk("z_free", 32'(free_valid), 32'd0);
        tick();
        cdb(1'b0, 4'd0); #1; chk_commit("nr_c2", 5'd11, 6'd57, 6'd11); tick();
        chk_cc("nr_cc", 26);

        // Flush with 5 valid entries and a done head
        for (int i = 0; i < 5; i++) begin
            disp(1'b1, 5'd12, 6'(50 + i)); #1;
            chk("fs_idx", 32'(disp_rob_idx), 32'(3 + i));
            tick();
        end
        disp_valid = 1'b0;
        cdb(1'b1, 4'd3); tick();
        flush = 1'b1; disp(1'b1, 5'd13, 6'd60); cdb(1'b1, 4'd4); #1;
        chk("fs_wen", 32'(rrf_w_en), 32'd0);
        chk("fs_free", 32'(free_valid), 32'd0);
        tick();
        flush = 1'b0; disp_valid = 1'b0; cdb(1'b1, 4'd2); #1;
        chk("fs_ready", 32'(disp_ready), 32'd1);
        chk("fs_idx0", 32'(disp_rob_idx), 32'd0);
        tick();
        cdb(1'b0, 4'd0); disp(1'b1, 5'd13, 6'd58); #1;
        chk("fs_redisp", 32'(disp_rob_idx), 32'd0);
        tick();
        disp_valid = 1'b0; #1; chk("fs_stale", 32'(rrf_w_en), 32'd0);
        cdb(1'b1, 4'd0); tick();
        cdb(1'b0, 4'd0); #1; chk_commit("fs_c", 5'd13, 6'd58, 6'd13); tick();
        chk_cc("fs_cc", 27);

        // rst while the head is committing
        disp(1'b1, 5'd14, 6'd59); #1; chk("rs_idx", 32'(disp_rob_idx), 32'd1); tick();
        disp_valid = 1'b0; cdb(1'b1, 4'd1); tick();
        cdb(1'b0, 4'd0); rst = 1'b1; #1;
        chk("rs_wen", 32'(rrf_w_en), 32'd0);
        chk("rs_free", 32'(free_valid), 32'd0);
        tick();
        rst = 1'b0; #1;
        chk("rs_ready", 32'(disp_ready), 32'd1);
        chk("rs_idx0", 32'(disp_rob_idx), 32'd0);
        chk("rs_wen2", 32'(rrf_w_en), 32'd0);
        chk("rs_free2", 32'(free_valid), 32'd0);
        chk("rs_cc", commit_count, 32'd0);
        chk("rs_rrf14", 32'(rrf[14]), 32'd14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order reorder buffer and commit stage for the explicit-renaming OoO core.
- Allocates entries at dispatch and marks them done from CDB writeback.
- Retires the oldest entry each cycle by writing its arch->phys mapping into the retirement register file (RRF).
- Returns the superseded physical register, read combinationally from the RRF, to the free list.

Parameters:
- ROB_DEPTH, 16, number of entries; power of two, at least 4.
- ROB_IDX, $clog2(ROB_DEPTH), width of an entry tag.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- disp_valid  in  1  dispatch request
- disp_ready  out  1  ROB can accept an entry this cycle
- disp_has_rd  in  1  instruction writes a destination register
- disp_arch_rd  in  5  architectural destination
- disp_phys_rd  in  PHYS_REG_ADDR  newly renamed physical destination
- disp_rob_idx  out  ROB_IDX  tag assigned to the dispatching entry (equals tail)
- cdb_valid  in  1  writeback broadcast
- cdb_rob_idx  in  ROB_IDX  tag of the completing entry
- flush  in  1  squash all entries
- rrf_r_addr  out  5  arch reg of the head entry, driven to the RRF read port
- rrf_r_data  in  PHYS_REG_ADDR  old mapping returned by the RRF
- rrf_w_en  out  1  RRF write enable
- rrf_w_addr  out  5  RRF write address
- rrf_w_data  out  PHYS_REG_ADDR  RRF write data
- free_valid  out  1  push to the free list
- free_preg  out  PHYS_REG_ADDR  physical register being freed
- commit_count  out  32  retired-instruction counter

Behaviour:
- Storage:
  - Circular buffer of entries {valid, done, has_rd, arch_rd, phys_rd}.
  - Pointers: head, tail (ROB_IDX bits); count (ROB_IDX+1 bits).
- Reset:
  - All valid/done cleared; head = tail = count = 0.
  - Outputs: disp_ready=1, rrf_w_en=0, free_valid=0, commit_count=0.
- Dispatch:
  - Fires when disp_valid && disp_ready; disp_ready = (count != ROB_DEPTH).
  - Full-cycle rule: disp_ready ignores a same-cycle commit, so dispatch is refused even if the head retires that cycle.
  - On fire, the entry at tail is written with valid=1, done=0; tail increments mod ROB_DEPTH, wrapping naturally.
  - disp_rob_idx always equals tail.
- Writeback:
  - cdb_valid sets done on entry cdb_rob_idx only if that entry is valid; otherwise ignored.
  - Done is visible to the commit logic the following cycle.
- Commit (combinational from registered head state):
  - Fires when entry[head].valid && entry[head].done; at most one per cycle.
  - rrf_r_addr = entry[head].arch_rd at all times, including when not committing.
  - When firing with has_rd=1 and arch_rd!=0:
    - rrf_w_en=1, rrf_w_addr=arch_rd, rrf_w_data=phys_rd.
    - free_valid=1, free_preg=rrf_r_data, i.e. the old mapping, since the RRF updates at the clock edge.
  - When firing with has_rd=0 or arch_rd==0: rrf_w_en=0 and free_valid=0; the entry still retires.
  - At the clock edge: head's valid clears, head increments mod ROB_DEPTH.
  - When not firing: rrf_w_en=0, free_valid=0.
- Count update:
  - +1 on dispatch only, -1 on commit only.
  - Unchanged when both fire, including when count==ROB_DEPTH-1.
- Empty: count==0 means no commit, whatever the CDB does.
- Flush:
  - Highest priority. Same cycle: rrf_w_en=0, free_valid=0, dispatch and CDB ignored.
  - Next cycle: head=tail=count=0, all valid cleared.
  - Free-list reconstruction is the free list's responsibility.
- rst overrides flush and all in-flight operations.

Optional Feature:
- Macro: ROB_COMMIT_COUNTER_EN.
- Defined: commit_count increments by 1 on every commit fire, including has_rd=0 commits.
  - Holds its value on flush; clears only on rst; wraps at 2^32.
- Undefined: no counter register is built; commit_count is tied to 0.

Decomposition:
- module_types package gains:
  - ROB_DEPTH_DEFAULT.
  - typedef rob_entry_t {valid, done, has_rd, arch_rd[4:0], phys_rd[PHYS_REG_ADDR-1:0]}.
- Reuses PHYS_REG_ADDR from module_types.
- No sub-module; the pointer/count logic stays inline.

Test Plan:
- Reset: dispatch 3 entries (arch 1/2/3 -> phys 40/41/42), CDB in order 0,1,2 -> three consecutive commits with rrf_w_addr 1,2,3 and rrf_w_data 40,41,42; free_preg equals the RRF's prior mappings 1,2,3.
- Out-of-order completion: CDB order 2,1,0 -> nothing commits until idx0 is done, then commits in order 0,1,2 on three consecutive cycles.
- Fill 16 entries -> disp_ready=0 and a 17th disp_valid is refused. Complete all, dispatch as the head commits -> tail wraps 15->0 and count holds at 15 or 16 correctly.
- Entry with arch_rd=0 or has_rd=0, done -> retires with rrf_w_en=0, free_valid=0; head advances; commit_count increments only under ROB_COMMIT_COUNTER_EN.
- Flush with 5 valid entries and a done head -> no RRF write that cycle; next cycle count=0, disp_ready=1, disp_rob_idx=0, and a stale CDB to idx 2 is ignored.
- rst asserted mid-stream with the head committing -> all outputs return to reset values the next cycle; RRF unwritten in the reset cycle.
